mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port `memory` block. Two requesters issue one read or write each. The arbiter grants one of them, range-checks the address against `MEM_SIZE`, and drives a single `wr`/`rd` strobe into the memory. It then waits for `response` and returns read data plus a completion pulse to the granted requester.

## Interface
- `ADDR_WIDTH`, 8, address width; matches `memory`.
- `DATA_WIDTH`, 16, data width; matches `memory`.
- `MEM_SIZE`, 16, number of valid words; legal addresses are 0..MEM_SIZE-1.
- `TIMEOUT`, 15, maximum WAIT cycles before abort; used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `m0_req` in 1: requester 0 request, level; held until `m0_done`.
- `m0_wr` in 1: 1 = write, 0 = read; stable while `m0_req` is high.
- `m0_addr` in ADDR_WIDTH: request address.
- `m0_wdata` in DATA_WIDTH: write data.
- `m0_gnt` out 1: one-cycle pulse; payload captured.
- `m0_done` out 1: one-cycle completion pulse.
- `m0_rdata` out DATA_WIDTH: read data, valid while `m0_done` is high.
- `m0_err` out 1: error flag, valid while `m0_done` is high.
- `m1_*`: identical set for requester 1.
- `mem_wr` out 1: write strobe to `memory`.
- `mem_rd` out 1: read strobe to `memory`.
- `mem_addr` out ADDR_WIDTH: address to `memory`.
- `mem_wdata` out DATA_WIDTH: write data to `memory`.
- `mem_rdata` in DATA_WIDTH: read data from `memory`.
- `mem_response` in 1: memory completion.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `req` is sampled high, select a winner, latch its `wr`/`addr`/`wdata`, and pulse its `gnt` in the next cycle.
  - Legal address: go to ISSUE.
  - Address >= MEM_SIZE: go to RESP with err=1, rdata=0, and no memory strobe.
- **ISSUE:** exactly one cycle of `mem_wr` or `mem_rd`, with `mem_addr`/`mem_wdata` from the latch. Next state WAIT.
- **WAIT:** strobes low. On `mem_response`=1, capture `mem_rdata` (reads) and go to RESP.
- **RESP:** winner's `done`=1 for one cycle, with `rdata`/`err`. Update the round-robin pointer to the winner. Next state IDLE.
- **Arbitration:**
  - Only a single request pending: it wins.
  - Both pending: the requester not served last wins.
  - After reset, requester 0 has priority.
- **Requester rule:** drop `req` on the edge after `done` is seen. If `req` is still high in the following IDLE cycle, it is a new request.
- `mem_response` arriving outside WAIT is ignored.
- Losing requester's `gnt`/`done`/`rdata`/`err` stay 0.
- `mem_addr`/`mem_wdata` hold their last value outside ISSUE; `rdata` is 0 outside `done`.

## Timing
- Reset values: all outputs 0, state IDLE, pointer favours requester 0.
- `req` sampled at edge E0 in IDLE:
  - gnt and mem strobe high in cycle E0–E1.
  - Memory samples the strobe at E1.
  - For a memory with one-cycle response, `response` is high in E1–E2 and done is high in E2–E3.
  - State is IDLE again after E3.
- Throughput with that memory: one transaction per 4 cycles.
- Out-of-range request: gnt and done both high in cycle E0–E1, err=1; back in IDLE after E1.
- Reset asserted mid-transaction, in any state:
  - Next cycle all outputs are 0 and state is IDLE.
  - The in-flight transaction is abandoned with no `done`.
  - A write already strobed may have landed in memory.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- **Defined:** a WAIT-cycle counter of width $clog2(TIMEOUT+1) is compiled in and cleared on entry to WAIT.
  - When the counter reaches TIMEOUT without `mem_response`, go to RESP with err=1 and rdata=0.
  - A response in the same cycle the count reaches TIMEOUT takes precedence (normal completion).
- **Undefined:** no counter; WAIT holds indefinitely until `mem_response`, and `busy` stays high.

## Test plan
- **Reset:** pulse `reset` for one cycle with no requests -> all outputs 0, `busy`=0. Any `mem_response` pulse is ignored.
- **Write then read, requester 0:** write addr 3, data 16'hA5A5, then read addr 3 -> for each transaction `m0_gnt`, then exactly one `mem_wr`/`mem_rd` pulse, then `m0_done` two edges after `gnt`. Read returns `m0_rdata`=16'hA5A5, `m0_err`=0.
- **Contention:** both requesters hold reads to addr 0..3 continuously from reset -> grants alternate m0,m1,m0,m1. Never two `gnt` in the same cycle; each `done` goes only to the granted requester.
- **Out of range:** m1 reads addr 16 (= MEM_SIZE) -> `m1_gnt` and `m1_done` in the same cycle, `m1_err`=1, `m1_rdata`=0, no `mem_rd`/`mem_wr` pulse. Memory contents unchanged.
- **Timeout:** memory model withholds `response`.
  - With `MEM_ARB_TIMEOUT_EN`: `done` with err=1 exactly TIMEOUT cycles after WAIT entry (15).
  - Without the macro: `busy` stays 1 and no `done`.
- **Reset in WAIT:** assert `reset` during WAIT -> next cycle all outputs 0 and no `done`. A following write/read to addr 5 (16'h1234) completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
//   m0_* / m1_* : requester handshake (req/wr/addr/wdata in, gnt/done/rdata/err out)
//   mem_*       : strobe/address/data towards memory, rdata/response back
//   busy        : arbiter is not idle
// Modports: slave = arbiter side, master = requester/memory environment side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  m0_req, m0_wr, m0_gnt, m0_done, m0_err;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;
  logic                  m1_req, m1_wr, m1_gnt, m1_done, m1_err;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;
  logic                  mem_wr, mem_rd, mem_response;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic                  busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  mem_rdata, mem_response,
    output m0_gnt, m0_done, m0_rdata, m0_err,
    output m1_gnt, m1_done, m1_rdata, m1_err,
    output mem_wr, mem_rd, mem_addr, mem_wdata, busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output mem_rdata, mem_response,
    input  m0_gnt, m0_done, m0_rdata, m0_err,
    input  m1_gnt, m1_done, m1_rdata, m1_err,
    input  mem_wr, mem_rd, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port memory.
// One request is granted at a time, its address is range-checked against
// MEM_SIZE, one wr/rd strobe is issued, and the memory response is returned
// to the winner as a one-cycle done pulse with rdata/err.
// Ports:
//   clk   : clock, posedge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (requester handshakes, memory bus, busy)
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without a memory response (done with err=1).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  // one extra bit so MEM_SIZE == 2**ADDR_WIDTH still compares correctly
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                state, state_nxt;
  logic [1:0]            req;
  req_t [1:0]            cmd;
  req_t                  sel;
  logic                  win_sel, in_range, timeout_hit;
  logic                  win_q, last_q, wr_q, err_q;
  logic [1:0]            gnt_q, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

  assign req    = {bus.m1_req, bus.m0_req};
  assign cmd[0] = {bus.m0_wr, bus.m0_addr, bus.m0_wdata};
  assign cmd[1] = {bus.m1_wr, bus.m1_addr, bus.m1_wdata};

  // lone requester wins; on contention the one not served last wins
  assign win_sel  = (&req) ? ~last_q : req[1];
  assign sel      = cmd[win_sel];
  assign in_range = {1'b0, sel.addr} < LIMIT;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // the edge on which the count would reach TIMEOUT ends the wait
  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)                wait_cnt <= '0;
    else if (state == ISSUE)  wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = in_range ? ISSUE : RESP;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.mem_response || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= 2'b00;
      win_q   <= 1'b0;
      last_q  <= 1'b1;   // requester 0 favoured after reset
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      gnt_q <= 2'b00;
      case (state)
        IDLE: if (|req) begin
          win_q   <= win_sel;
          wr_q    <= sel.wr;
          err_q   <= ~in_range;
          rdata_q <= '0;
          gnt_q   <= win_sel ? 2'b10 : 2'b01;
          // memory bus only moves for requests that will actually be issued
          if (in_range) begin
            addr_q  <= sel.addr;
            wdata_q <= sel.wdata;
          end
        end
        WAIT: begin
          // a response on the timeout edge still counts as normal completion
          if (bus.mem_response) begin
            rdata_q <= wr_q ? '0 : bus.mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        RESP:    last_q <= win_q;
        default: ;
      endcase
    end
  end

  assign done = (state == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_done   = done[0];
  assign bus.m1_done   = done[1];
  assign bus.m0_err    = done[0] & err_q;
  assign bus.m1_err    = done[1] & err_q;
  assign bus.m0_rdata  = done[0] ? rdata_q : '0;
  assign bus.m1_rdata  = done[1] ? rdata_q : '0;
  assign bus.mem_wr    = (state == ISSUE) &  wr_q;
  assign bus.mem_rd    = (state == ISSUE) & ~wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model with one-cycle response,
// per-requester request queues, and a transaction-level reference (shadow
// memory plus last-served pointer) predicting grant order and read data.
module tb_mem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int MSZ = 16;
  localparam int TMO = 15;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } txn_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MSZ), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memory model: samples a strobe, answers one cycle later unless withheld
  logic [DW-1:0] mem_arr [0:255];
  logic          resp_q   = 1'b0;
  logic          stray    = 1'b0;
  logic          withhold = 1'b0;
  logic [DW-1:0] mrd_q    = '0;

  assign bus.mem_response = resp_q | stray;
  assign bus.mem_rdata    = mrd_q;

  always @(posedge clk) begin
    resp_q <= 1'b0;
    if (!withhold && (bus.mem_wr === 1'b1 || bus.mem_rd === 1'b1)) begin
      resp_q <= 1'b1;
      if (bus.mem_wr === 1'b1) mem_arr[bus.mem_addr] = bus.mem_wdata;
      else                     mrd_q <= mem_arr[bus.mem_addr];
    end
  end

  // activity counters
  int cnt_wr = 0, cnt_rd = 0, cnt_done = 0, cnt_dual = 0;
  always @(posedge clk) begin
    if (bus.mem_wr === 1'b1)  cnt_wr++;
    if (bus.mem_rd === 1'b1)  cnt_rd++;
    if (bus.m0_done === 1'b1) cnt_done++;
    if (bus.m1_done === 1'b1) cnt_done++;
    if (bus.m0_gnt === 1'b1 && bus.m1_gnt === 1'b1) cnt_dual++;
  end

  // reference state
  logic [DW-1:0] ref_mem [0:MSZ-1];
  bit            last_srv = 1'b1;
  txn_t          q0[$], q1[$];
  int            exp_wr = 0, exp_rd = 0, exp_done = 0;
  int            n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] all_outs();
    return 80'({bus.m0_gnt, bus.m0_done, bus.m0_err, bus.m0_rdata,
                bus.m1_gnt, bus.m1_done, bus.m1_err, bus.m1_rdata,
                bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata, bus.busy});
  endfunction

  function automatic logic gnt_of(input bit p);
    return p ? bus.m1_gnt : bus.m0_gnt;
  endfunction
  function automatic logic done_of(input bit p);
    return p ? bus.m1_done : bus.m0_done;
  endfunction
  function automatic logic err_of(input bit p);
    return p ? bus.m1_err : bus.m0_err;
  endfunction
  function automatic logic [DW-1:0] rd_of(input bit p);
    return p ? bus.m1_rdata : bus.m0_rdata;
  endfunction

  task automatic load_ports();
    if (q0.size() > 0) begin
      bus.m0_req = 1'b1; bus.m0_wr = q0[0].wr; bus.m0_addr = q0[0].addr; bus.m0_wdata = q0[0].wd;
    end else bus.m0_req = 1'b0;
    if (q1.size() > 0) begin
      bus.m1_req = 1'b1; bus.m1_wr = q1[0].wr; bus.m1_addr = q1[0].addr; bus.m1_wdata = q1[0].wd;
    end else bus.m1_req = 1'b0;
  endtask

  task automatic push(input bit p, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wd = wd;
    if (p) q1.push_back(t); else q0.push_back(t);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    last_srv = 1'b1;
  endtask

  // Serve both queues to completion, checking every transaction's timing.
  task automatic run_queues();
    txn_t t;
    bit   w, oob;
    int   guard;
    @(posedge clk); #1; load_ports();
    while (q0.size() + q1.size() > 0) begin
      w   = (q0.size() > 0 && q1.size() > 0) ? ~last_srv : (q1.size() > 0);
      t   = w ? q1[0] : q0[0];
      oob = (t.addr >= MSZ);
      guard = 0;
      do begin @(negedge clk); guard++; end
      while (!(bus.m0_gnt === 1'b1 || bus.m1_gnt === 1'b1) && guard < 10);
      check("gnt_latency", 80'(guard), 80'(2));
      check("gnt_onehot", 80'({bus.m1_gnt, bus.m0_gnt}), 80'(w ? 2'b10 : 2'b01));
      if (oob) begin
        check("oob_strobe", 80'({bus.mem_wr, bus.mem_rd}), 80'(0));
      end else begin
        check("issue_strobe", 80'({bus.mem_wr, bus.mem_rd}), 80'({t.wr, ~t.wr}));
        check("issue_addr", 80'(bus.mem_addr), 80'(t.addr));
        if (t.wr) check("issue_wdata", 80'(bus.mem_wdata), 80'(t.wd));
        check("early_done", 80'({bus.m1_done, bus.m0_done}), 80'(0));
        @(negedge clk);
        check("wait_quiet", 80'({bus.mem_wr, bus.mem_rd, bus.m1_gnt, bus.m0_gnt,
                                 bus.m1_done, bus.m0_done}), 80'(0));
        @(negedge clk);
        if (t.wr) exp_wr++; else exp_rd++;
      end
      check("done_onehot", 80'({bus.m1_done, bus.m0_done}), 80'(w ? 2'b10 : 2'b01));
      check("done_err", 80'(err_of(w)), 80'(oob));
      if (oob)        check("oob_rdata", 80'(rd_of(w)), 80'(0));
      else if (!t.wr) check("rdata", 80'(rd_of(w)), 80'(ref_mem[t.addr[3:0]]));
      check("loser_quiet", 80'({gnt_of(!w), done_of(!w), err_of(!w), rd_of(!w)}), 80'(0));
      if (!oob && t.wr) ref_mem[t.addr[3:0]] = t.wd;
      exp_done++;
      last_srv = w;
      if (w) void'(q1.pop_front()); else void'(q0.pop_front());
      @(posedge clk); #1; load_ports();
    end
  endtask

  initial begin
    int guard, saw_done, saw_idle, sel, n;
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = '0;
    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

    // reset state, stray response, one-cycle reset pulse
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outs", all_outs(), 80'(0));
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    @(negedge clk);
    check("stray_resp_outs", all_outs(), 80'(0));
    do_reset();
    @(negedge clk);
    check("reset_pulse_outs", all_outs(), 80'(0));

    // requester 0 write then read of addr 3
    push(1'b0, 1'b1, 8'd3, 16'hA5A5);
    push(1'b0, 1'b0, 8'd3, 16'h0000);
    run_queues();

    // out-of-range on requester 1: read at MEM_SIZE, write just beyond
    push(1'b1, 1'b0, 8'd16, 16'h0000);
    push(1'b1, 1'b1, 8'd17, 16'hDEAD);
    run_queues();

    // randomized single/dual-requester rounds
    for (int r = 0; r < 25; r++) begin
      sel = $urandom_range(0, 2);
      if (sel != 1) begin
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++)
          push(1'b0, 1'($urandom), 8'($urandom_range(0, 19)), 16'($urandom));
      end
      if (sel != 0) begin
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++)
          push(1'b1, 1'($urandom), 8'($urandom_range(0, 19)), 16'($urandom));
      end
      run_queues();
    end

    // contention: seed addr 0..3, then both hold reads from reset
    for (int a = 0; a < 4; a++) push(1'b0, 1'b1, 8'(a), 16'($urandom));
    run_queues();
    for (int a = 0; a < 4; a++) begin
      push(1'b0, 1'b0, 8'(a), 16'h0000);
      push(1'b1, 1'b0, 8'(a), 16'h0000);
    end
    do_reset();
    run_queues();

    // memory withholds its response
    withhold = 1'b1;
    push(1'b0, 1'b0, 8'd2, 16'h0000);
    @(posedge clk); #1; load_ports();
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (bus.m0_gnt !== 1'b1 && guard < 10);
    check("to_gnt", 80'({bus.m1_gnt, bus.m0_gnt, bus.mem_rd}), 80'(3'b011));
    exp_rd++;
`ifdef MEM_ARB_TIMEOUT_EN
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (bus.m0_done !== 1'b1 && guard < 40);
    check("to_latency", 80'(guard), 80'(TMO + 1));
    check("to_err", 80'(bus.m0_err), 80'(1));
    check("to_rdata", 80'(bus.m0_rdata), 80'(0));
    exp_done++;
    last_srv = 1'b0;
    @(posedge clk); #1;
    void'(q0.pop_front()); load_ports();
    withhold = 1'b0;
`else
    saw_done = 0; saw_idle = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.m0_done !== 1'b0 || bus.m1_done !== 1'b0) saw_done++;
      if (bus.busy !== 1'b1) saw_idle++;
    end
    check("hang_no_done", 80'(saw_done), 80'(0));
    check("hang_busy", 80'(saw_idle), 80'(0));
    void'(q0.pop_front()); load_ports();
    withhold = 1'b0;
    do_reset();
`endif

    // reset while in WAIT, then a normal write/read of addr 5
    withhold = 1'b1;
    push(1'b0, 1'b1, 8'd5, 16'hBEEF);
    @(posedge clk); #1; load_ports();
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (bus.m0_gnt !== 1'b1 && guard < 10);
    check("rw_gnt", 80'({bus.m0_gnt, bus.mem_wr}), 80'(2'b11));
    exp_wr++;
    @(negedge clk);
    check("rw_in_wait", 80'(bus.busy), 80'(1));
    reset = 1'b1;
    void'(q0.pop_front()); load_ports();
    @(posedge clk); #1 reset = 1'b0;
    last_srv = 1'b1;
    withhold = 1'b0;
    @(negedge clk);
    check("rw_reset_outs", all_outs(), 80'(0));
    push(1'b0, 1'b1, 8'd5, 16'h1234);
    push(1'b0, 1'b0, 8'd5, 16'h0000);
    run_queues();

    // totals and final memory image
    repeat (3) @(negedge clk);
    check("cnt_mem_wr", 80'(cnt_wr), 80'(exp_wr));
    check("cnt_mem_rd", 80'(cnt_rd), 80'(exp_rd));
    check("cnt_done", 80'(cnt_done), 80'(exp_done));
    check("cnt_dual_gnt", 80'(cnt_dual), 80'(0));
    check("oob_untouched16", 80'(mem_arr[16]), 80'(0));
    check("oob_untouched17", 80'(mem_arr[17]), 80'(0));
    for (int i = 0; i < MSZ; i++) check("mem_image", 80'(mem_arr[i]), 80'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
